seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
Time-multiplexed driver for a 4-digit 7-segment display. It consumes the four 8-bit segment patterns produced by the per-digit segment decoders and scans one digit at a time onto a shared segment bus with one-hot anode enables. Each slot starts with a dead-time blanking gap to prevent ghosting. All four patterns are snapshotted once per frame so the display never tears mid-scan. It sits directly downstream of decode_seg and drives the board pins.

Parameters:
DIV_WIDTH, 16, width of slot cycle counter
DIV_MAX, 999, slot length minus 1 (slot = DIV_MAX+1 clk cycles); must be >= BLANK_CYCLES
BLANK_CYCLES, 8, dead-time cycles at start of each slot; 0 disables blanking
SEG_OFF, 8'hFF, seg_out value when no digit is lit
AN_ON, 1'b0, anode level that enables a digit (inactive = ~AN_ON)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
enable  in  1  1 = scan, 0 = display dark and scanner idle
seg0  in  8  segment pattern, digit 0 (rightmost)
seg1  in  8  segment pattern, digit 1
seg2  in  8  segment pattern, digit 2
seg3  in  8  segment pattern, digit 3
blank_mask  in  4  bit i = 1 keeps digit i dark (leading-zero blanking)
seg_out  out  8  shared segment bus
an_out  out  4  anode enables, bit i = digit i
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- States: IDLE, BLANK, ON. Registers: digit (2b), cnt (DIV_WIDTH), shadow seg[0..3], shadow mask.
- Reset (reset=0, async): state=IDLE, digit=0, cnt=0, shadows=0, seg_out=SEG_OFF, an_out all ~AN_ON, frame_done=0. Takes effect immediately, including mid-slot.
- Outputs are registered and aligned with state: they reflect the current cycle's state with no added latency.
- IDLE: outputs dark. An edge with enable=1 loads shadows from seg0..3/blank_mask, sets digit=0, cnt=0, and enters BLANK (or ON if BLANK_CYCLES=0).
- Slot timing: cnt runs 0..DIV_MAX. Cycles with cnt < BLANK_CYCLES are BLANK: an all inactive, seg_out=SEG_OFF. Remaining cycles are ON: an_out[digit]=AN_ON, others inactive, seg_out=shadow[digit].
- ON with shadow mask[digit]=1: behaves as BLANK (dark) for the whole slot; timing is unchanged.
- Slot end (cnt=DIV_MAX): cnt->0, digit->digit+1. digit 3 wraps to 0.
- Wrap from digit 3 to 0: shadows reload from the live inputs on the same edge, and frame_done=1 for exactly that first cycle of the new frame. The first frame after leaving IDLE produces no frame_done.
- Live input changes mid-frame are not visible until the next snapshot.
- enable=0 at any edge: next state IDLE, outputs dark, frame_done=0, digit/cnt cleared. Shadows are held but reloaded on restart.
- At most one an_out bit is active in any cycle. Two digits are never lit in the same cycle across a slot boundary.
- Frame length = 4*(DIV_MAX+1) cycles.

Test Plan:
- Reset/idle: reset=0 then 1, enable=0 for 20 cycles -> seg_out=8'hFF, an_out=4'b1111, frame_done=0 throughout; reset=0 mid-ON forces dark in the same cycle.
- Basic scan, DIV_MAX=9, BLANK_CYCLES=2, seg0..3=8'hC0,8'hF9,8'hA4,8'hB0, enable=1 from edge 1:
  - Edges 1-2 -> an 4'b1111, seg FF.
  - Edges 3-10 -> an 4'b1110, seg C0.
  - Edge 11 -> digit 1 blank.
  - Edges 13-20 -> an 4'b1101, seg F9; pattern continues through digit 3.
  - Edge 41 -> digit 0 blank, frame_done=1 for one cycle only.
- Snapshot: change seg1 to 8'h80 at edge 15 (mid digit-1 ON) -> digit 1 shows F9 until edge 40; shows 80 from edge 53.
- blank_mask=4'b1100, same stimulus -> digits 2,3 dark for their full 10-cycle slots; digits 0,1 unchanged; frame_done still every 40 cycles.
- BLANK_CYCLES=0, DIV_MAX=3 -> no dark cycles; an_out steps 1110,1101,1011,0111 every 4 cycles; never two bits low.
- enable dropped at edge 25, raised at edge 30 -> dark from edge 25; edge 30 restarts digit 0 blank with fresh snapshot; no frame_done until 40 cycles later.

Source files
------------

// File: rtl/seg_scan_mux_if.sv
// Segment-scan bus: upstream patterns/controls in, display pin drive out.
// master = whoever supplies the patterns; slave = the scanner.
interface seg_scan_mux_if;
  logic       enable;
  logic [7:0] seg0;
  logic [7:0] seg1;
  logic [7:0] seg2;
  logic [7:0] seg3;
  logic [3:0] blank_mask;
  logic [7:0] seg_out;
  logic [3:0] an_out;
  logic       frame_done;

  modport master (
    output enable, seg0, seg1, seg2, seg3, blank_mask,
    input  seg_out, an_out, frame_done
  );

  modport slave (
    input  enable, seg0, seg1, seg2, seg3, blank_mask,
    output seg_out, an_out, frame_done
  );
endinterface

// File: rtl/seg_scan_mux.sv
// 4-digit 7-segment scanner with per-slot dead time and per-frame pattern snapshot.
// Outputs are registered from next-state values so they line up with the state register.
module seg_scan_mux #(
  parameter int          DIV_WIDTH    = 16,
  parameter int          DIV_MAX      = 999,
  parameter int          BLANK_CYCLES = 8,
  parameter logic [7:0]  SEG_OFF      = 8'hFF,
  parameter logic        AN_ON        = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  seg_scan_mux_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(DIV_MAX);
  localparam logic [3:0]           AN_OFF   = {4{~AN_ON}};

  state_t               state, state_n;
  logic [1:0]           digit, digit_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [7:0]           shadow   [4];
  logic [7:0]           shadow_n [4];
  logic [3:0]           mask, mask_n;
  logic                 load;
  logic [7:0]           seg_n;
  logic [3:0]           an_n;
  logic                 fd_n;

  always_comb begin
    state_n  = state;
    digit_n  = digit;
    cnt_n    = cnt;
    shadow_n = shadow;
    mask_n   = mask;
    fd_n     = 1'b0;
    load     = 1'b0;
    seg_n    = SEG_OFF;
    an_n     = AN_OFF;

    if (!bus.enable) begin
      state_n = IDLE;
      digit_n = '0;
      cnt_n   = '0;
    end else begin
      if (state == IDLE) begin
        digit_n = '0;
        cnt_n   = '0;
        load    = 1'b1;
      end else if (cnt == CNT_LAST) begin
        cnt_n   = '0;
        digit_n = digit + 2'd1;
        if (digit == 2'd3) begin
          load = 1'b1;
          fd_n = 1'b1;
        end
      end else begin
        cnt_n = cnt + DIV_WIDTH'(1);
      end
      // Signed compare keeps BLANK_CYCLES=0 a clean "never blank" case.
      state_n = (int'(cnt_n) < BLANK_CYCLES) ? BLANK : ON;
    end

    if (load) begin
      shadow_n = '{bus.seg0, bus.seg1, bus.seg2, bus.seg3};
      mask_n   = bus.blank_mask;
    end

    if (state_n == ON && !mask_n[digit_n]) begin
      seg_n          = shadow_n[digit_n];
      an_n[digit_n]  = AN_ON;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      digit          <= '0;
      cnt            <= '0;
      shadow         <= '{default: '0};
      mask           <= '0;
      bus.seg_out    <= SEG_OFF;
      bus.an_out     <= AN_OFF;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_n;
      digit          <= digit_n;
      cnt            <= cnt_n;
      shadow         <= shadow_n;
      mask           <= mask_n;
      bus.seg_out    <= seg_n;
      bus.an_out     <= an_n;
      bus.frame_done <= fd_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: two instances (with and without dead time)
// driven with identical stimulus and checked against a slot/frame arithmetic model.
module tb_seg_scan_mux;

  typedef struct {
    logic [7:0] seg;
    logic [7:0] an;
    logic [7:0] fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic [7:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
  logic [3:0] msk = '0;

  int tests = 0;
  int fails = 0;

  exp_t sb[$];

  int         slot_len [2] = '{10, 4};
  int         blank_len[2] = '{2, 0};
  int         k        [2];
  bit         act      [2];
  logic [7:0] sh       [2][4];
  logic [3:0] msh      [2];
  bit         lit_a;

  seg_scan_mux_if ifa ();
  seg_scan_mux_if ifb ();

  assign ifa.enable = en;  assign ifb.enable = en;
  assign ifa.seg0 = s0;    assign ifb.seg0 = s0;
  assign ifa.seg1 = s1;    assign ifb.seg1 = s1;
  assign ifa.seg2 = s2;    assign ifb.seg2 = s2;
  assign ifa.seg3 = s3;    assign ifb.seg3 = s3;
  assign ifa.blank_mask = msk;
  assign ifb.blank_mask = msk;

  seg_scan_mux #(.DIV_WIDTH(16), .DIV_MAX(9), .BLANK_CYCLES(2),
                 .SEG_OFF(8'hFF), .AN_ON(1'b0))
    dut_a (.clk(clk), .reset(rst), .bus(ifa.slave));

  seg_scan_mux #(.DIV_WIDTH(16), .DIV_MAX(3), .BLANK_CYCLES(0),
                 .SEG_OFF(8'hFF), .AN_ON(1'b0))
    dut_b (.clk(clk), .reset(rst), .bus(ifb.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Predict what instance id shows after the coming edge, given the inputs it will sample.
  task automatic model(input int id);
    exp_t e;
    int   slot, pos, frame;
    bit   lit;
    frame = 4 * slot_len[id];
    e.seg = 8'hFF; e.an = 8'h0F; e.fd = 8'h00;
    lit = 1'b0;
    if (!en) begin
      act[id] = 1'b0;
    end else begin
      if (!act[id]) begin
        act[id] = 1'b1;
        k[id]   = 0;
      end else begin
        k[id]++;
      end
      if (k[id] % frame == 0) begin
        sh[id] = '{s0, s1, s2, s3};
        msh[id] = msk;
      end
      slot = (k[id] / slot_len[id]) % 4;
      pos  = k[id] % slot_len[id];
      lit  = (pos >= blank_len[id]) && !msh[id][slot];
      if (lit) begin
        e.seg = sh[id][slot];
        e.an  = 8'h0F & ~(8'h01 << slot);
      end
      if (k[id] != 0 && k[id] % frame == 0) e.fd = 8'h01;
    end
    if (id == 0) lit_a = lit;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model(0);
    model(1);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("a_seg", ifa.seg_out, e.seg);
    chk("a_an",  {4'h0, ifa.an_out}, e.an);
    chk("a_fd",  {7'h0, ifa.frame_done}, e.fd);
    e = sb.pop_front();
    chk("b_seg", ifb.seg_out, e.seg);
    chk("b_an",  {4'h0, ifb.an_out}, e.an);
    chk("b_fd",  {7'h0, ifb.frame_done}, e.fd);
    chk("a_onehot", 8'($countones(~ifa.an_out) <= 1), 8'h01);
    chk("b_onehot", 8'($countones(~ifb.an_out) <= 1), 8'h01);
  endtask

  initial begin
    act = '{0, 0};
    k   = '{0, 0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_seg", ifa.seg_out, 8'hFF);
    chk("rst_a_an",  {4'h0, ifa.an_out}, 8'h0F);
    chk("rst_a_fd",  {7'h0, ifa.frame_done}, 8'h00);
    chk("rst_b_an",  {4'h0, ifb.an_out}, 8'h0F);
    @(negedge clk);
    rst = 1'b1;

    // Idle with enable low
    repeat (20) step();

    // Basic scan; seg1 changes mid digit-1 ON (edge 15), visible only next frame
    s0 = 8'hC0; s1 = 8'hF9; s2 = 8'hA4; s3 = 8'hB0;
    en = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      if (e == 15) s1 = 8'h80;
      step();
    end

    // Enable dropout and restart with a fresh snapshot
    s1 = 8'hF9;
    en = 1'b0;
    repeat (5) step();
    en = 1'b1;
    repeat (45) step();

    // Leading-zero blanking of digits 2 and 3 from the next snapshot
    msk = 4'b1100;
    repeat (50) step();
    msk = 4'b0000;

    // Asynchronous reset while digit is lit
    begin
      int n = 0;
      do begin
        step();
        n++;
      end while (!lit_a && n < 20);
      chk("reach_on", 8'(lit_a), 8'h01);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("arst_a_seg", ifa.seg_out, 8'hFF);
    chk("arst_a_an",  {4'h0, ifa.an_out}, 8'h0F);
    chk("arst_b_an",  {4'h0, ifb.an_out}, 8'h0F);
    act = '{0, 0};
    @(negedge clk);
    rst = 1'b1;
    repeat (45) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
